// File: rtl/forth_uart_tx_if.sv
// forth_uart_tx_if: CPU data-port bundle between the forth CPU and the UART transmitter.
//   daddr       - CPU data address
//   ddata_write - CPU store data
//   dwrite      - CPU store strobe
//   ddata_read  - read data back to the CPU (zero when the peripheral is not selected)
//   sel         - peripheral selected by daddr
interface forth_uart_tx_if;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic        dwrite;
  logic [15:0] ddata_read;
  logic        sel;

  modport master (
    output daddr,
    output ddata_write,
    output dwrite,
    input  ddata_read,
    input  sel
  );

  modport slave (
    input  daddr,
    input  ddata_write,
    input  dwrite,
    output ddata_read,
    output sel
  );
endinterface

// File: rtl/forth_uart_tx.sv
// forth_uart_tx: memory-mapped 8N1 UART transmitter for the forth CPU data port.
// CPU stores to BASE are queued in a small FIFO and serialised LSB first onto txd.
// STATUS at BASE+1 reports {count, 4'b0, overflow, busy, empty, full}; writing it with
// bit 3 set clears the sticky overflow flag.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - CPU data port (slave side): daddr, ddata_write, dwrite, ddata_read, sel
//   txd   - serial output, idle high
module forth_uart_tx #(
  parameter logic [7:0]  BASE         = 8'hF0,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH_LOG2   = 3
) (
  input  logic           clk,
  input  logic           reset,
  forth_uart_tx_if.slave bus,
  output logic           txd
);

  localparam int unsigned          DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned          BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [7:0]           STAT_ADDR = BASE + 8'd1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]    BAUD_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]  CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE   = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  r_ovf;

  // Transmit FSM
  state_e                r_state;
  state_e                w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_next;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_next;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_next;

  logic w_sel_data;
  logic w_sel_stat;
  logic w_full;
  logic w_empty;
  logic w_busy;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic w_baud_done;
  logic w_unused_wdata;

  assign w_sel_data = (bus.daddr == BASE);
  assign w_sel_stat = (bus.daddr == STAT_ADDR);
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != StIdle);

  assign w_pop      = (r_state == StIdle) && !w_empty;
  assign w_push_req = bus.dwrite && w_sel_data;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push;
  assign w_ovf_clr  = bus.dwrite && w_sel_stat && bus.ddata_write[3];

  assign w_baud_done = (r_baud == BAUD_LAST);

  // Only the low byte of a store carries data.
  assign w_unused_wdata = ^bus.ddata_write[15:8];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.ddata_write[7:0];
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_next = StStart;
          w_baud_next  = '0;
          w_shift_next = r_mem[r_rd_ptr];
        end
      end
      StStart: begin
        if (w_baud_done) begin
          w_state_next = StData;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      StData: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_next = StStop;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      StStop: begin
        if (w_baud_done) begin
          w_state_next = StIdle;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // txd decoded straight from state so an asynchronous reset forces idle high at once.
  always_comb begin
    txd = 1'b1;
    case (r_state)
      StStart: txd = 1'b0;
      StData:  txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path: zero when not selected so it can be OR-ed with the RAM read bus
  // ---------------------------------------------------------------------------
  assign bus.sel = w_sel_data | w_sel_stat;

  always_comb begin
    bus.ddata_read = '0;
    if (w_sel_stat) begin
      bus.ddata_read = {8'(r_count), 4'b0000, r_ovf, w_busy, w_empty, w_full};
    end
  end

endmodule

// File: tb/tb_forth_uart_tx.sv
module tb_forth_uart_tx;
  localparam int unsigned C    = 4;
  localparam logic [7:0]  BASE = 8'hF0;
  localparam logic [7:0]  STAT = 8'hF1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic txd;

  forth_uart_tx_if bus ();

  forth_uart_tx #(
    .BASE         (BASE),
    .CLKS_PER_BIT (C),
    .DEPTH_LOG2   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: FIFO occupancy, transmitter busy time, sticky overflow.
  int         m_count = 0;
  int         m_busy  = 0;
  bit         m_ovf   = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_status();
    return {8'(m_count), 4'b0000, m_ovf, (m_busy != 0), (m_count == 0), (m_count == 8)};
  endfunction

  // One frame occupies the transmitter for 10 bit times; a byte leaves the queue when
  // the transmitter has been free for a full cycle.
  task automatic model_step();
    bit pop, req, accept;
    if (!reset) begin
      m_count = 0;
      m_busy  = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
      return;
    end
    pop    = (m_busy == 0) && (m_count > 0);
    req    = bus.dwrite && (bus.daddr == BASE);
    accept = req && ((m_count < 8) || pop);
    if (pop) begin
      m_count--;
      m_busy = 10 * C;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (accept) begin
      m_count++;
      exp_q.push_back(bus.ddata_write[7:0]);
    end else if (req) begin
      m_ovf = 1'b1;
    end
    if (bus.dwrite && (bus.daddr == STAT) && bus.ddata_write[3]) m_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    bus.daddr       = addr;
    bus.ddata_write = data;
    bus.dwrite      = 1'b1;
    tick();
    bus.dwrite      = 1'b0;
  endtask

  task automatic idle_chk(input string name);
    bus.dwrite = 1'b0;
    bus.daddr  = STAT;
    #1;
    chk(name, bus.ddata_read, model_status());
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    bus.dwrite = 1'b0;
    while ((m_count != 0 || m_busy != 0) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout: count=%0d busy=%0d after %0d cycles", m_count, m_busy, k);
    end
  endtask

  // Monitor: decode each frame from txd, compare every cycle with the next expected byte.
  initial begin : monitor
    logic [9:0] fr;
    logic [7:0] b;
    bit         ok;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset && txd === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_frame: start bit with no byte expected (cycle %0d)", cyc);
          b = 8'h00;
        end else begin
          b = exp_q.pop_front();
        end
        fr      = {1'b1, b, 1'b0};
        ok      = 1'b1;
        aborted = 1'b0;
        for (int j = 0; j < 10 * C; j++) begin
          if (j > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (txd !== fr[j / C]) ok = 1'b0;
        end
        if (!aborted) chk($sformatf("frame_%02h", b), {31'd0, ok}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int n0;
    int k;
    logic [7:0] a;
    bus.daddr       = STAT;
    bus.ddata_write = '0;
    bus.dwrite      = 1'b0;

    // Reset state, read path live during reset
    #12;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_status", bus.ddata_read, 32'h0002);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();

    // Single byte A5
    wr(BASE, 16'h12A5);
    chk("pre_start_txd", {31'd0, txd}, 32'd1);
    tick();
    chk("start_latency_txd", {31'd0, txd}, 32'd0);
    idle_chk("busy_status");
    chk("busy_bit", bus.ddata_read[2], 32'd1);
    wait_idle(200);
    tick();
    idle_chk("after_frame_status");
    chk("after_frame_const", bus.ddata_read, 32'h0002);

    // Fill and overflow: first byte goes on the wire, 8 queue, the 10th is dropped
    for (int i = 0; i < 10; i++) wr(BASE, 16'($urandom));
    idle_chk("fill_status");
    chk("fill_full_ovf", bus.ddata_read, 32'h080D);
    wr(STAT, 16'h0008);
    idle_chk("ovf_clear_status");
    chk("ovf_clear_const", bus.ddata_read, 32'h0805);

    // Push while full on the edge the FSM pops
    k = 0;
    bus.daddr = STAT;
    while (m_busy != 0 && k < 200) begin
      tick();
      k++;
    end
    wr(BASE, 16'($urandom));
    idle_chk("push_pop_full_status");
    chk("push_pop_full_const", bus.ddata_read, 32'h0805);
    wait_idle(1000);

    // Back-to-back frames
    n0 = starts.size();
    wr(BASE, 16'h0000);
    wr(BASE, 16'h00FF);
    k = 0;
    while (starts.size() < n0 + 2 && k < 200) begin
      tick();
      k++;
    end
    if (starts.size() >= n0 + 2) begin
      chk("b2b_spacing", starts[n0 + 1] - starts[n0], 32'd41);
    end else begin
      n_total++;
      n_bad++;
      $display("FAIL b2b_timeout: frames seen %0d required 2", starts.size() - n0);
    end
    wait_idle(200);

    // Address decode
    wr(8'hF2, 16'h0055);
    bus.daddr = 8'hF2;
    #1;
    chk("sel_f2", {31'd0, bus.sel}, 32'd0);
    chk("rd_f2", bus.ddata_read, 32'd0);
    bus.daddr = 8'h00;
    #1;
    chk("sel_00", {31'd0, bus.sel}, 32'd0);
    chk("rd_00", bus.ddata_read, 32'd0);
    bus.daddr = BASE;
    #1;
    chk("sel_base", {31'd0, bus.sel}, 32'd1);
    chk("rd_base", bus.ddata_read, 32'd0);
    tick();
    idle_chk("decode_status");
    chk("decode_const", bus.ddata_read, 32'h0002);

    // Reset during data bit 3
    wr(BASE, 16'h003C);
    wr(BASE, 16'h0081);
    repeat (16) tick();
    #1;
    reset = 1'b0;
    #1;
    chk("midframe_reset_txd", {31'd0, txd}, 32'd1);
    m_count = 0;
    m_busy  = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    idle_chk("post_reset_status");
    chk("post_reset_const", bus.ddata_read, 32'h0002);
    n0 = starts.size();
    repeat (60) tick();
    chk("no_residual_frame", starts.size(), n0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: wr(BASE, 16'($urandom));
        3:       wr(STAT, 16'($urandom));
        4: begin
          a = 8'($urandom);
          if (a == BASE || a == STAT) a = 8'h10;
          wr(a, 16'($urandom));
          bus.daddr = a;
          #1;
          chk("rand_sel_other", {31'd0, bus.sel}, 32'd0);
        end
        default: tick();
      endcase
      idle_chk("rand_status");
    end
    wait_idle(2000);
    repeat (5) tick();
    idle_chk("final_status");
    chk("all_frames_seen", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
